// File: rtl/and_gate.sv
// ============================================================================
//  and_gate : combinational AND with registered copy and saturating counters
//  Optional high-cycle counter compiled in by AND_GATE_HIGH_CNT_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module and_gate #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             clr,
   output logic             out,
   output logic             out_q,
   output logic [CNT_W-1:0] rise_cnt,
   output logic             rise_sat
`ifdef AND_GATE_HIGH_CNT_EN
  ,output logic [CNT_W-1:0] high_cnt
`endif
);

   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             out_d;
   logic [CNT_W-1:0] rise_cnt_q;
   logic [CNT_W-1:0] rise_cnt_d;
   logic             rise_sat_q;
   logic             rise_sat_d;

   // Plain AND keeps 0-dominance: a known 0 on either input masks an X.
   assign out = a & b;

   always_comb begin
      out_d      = a & b;
      rise_cnt_d = rise_cnt_q;
      if (clr) begin
         rise_cnt_d = '0;
      end else if (out_d && !out_q && (rise_cnt_q != C_CNT_MAX)) begin
         rise_cnt_d = rise_cnt_q + C_CNT_ONE;
      end
      rise_sat_d = (rise_cnt_d == C_CNT_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q      <= 1'b0;
         rise_cnt_q <= '0;
         rise_sat_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         rise_cnt_q <= rise_cnt_d;
         rise_sat_q <= rise_sat_d;
      end
   end

   assign rise_cnt = rise_cnt_q;
   assign rise_sat = rise_sat_q;

`ifdef AND_GATE_HIGH_CNT_EN
   logic [CNT_W-1:0] high_cnt_q;
   logic [CNT_W-1:0] high_cnt_d;

   // Counts edges whose newly loaded out_q is 1, i.e. out_d at that edge.
   always_comb begin
      high_cnt_d = high_cnt_q;
      if (clr) begin
         high_cnt_d = '0;
      end else if (out_d && (high_cnt_q != C_CNT_MAX)) begin
         high_cnt_d = high_cnt_q + C_CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         high_cnt_q <= '0;
      end else begin
         high_cnt_q <= high_cnt_d;
      end
   end

   assign high_cnt = high_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_and_gate.sv
// ============================================================================
//  tb_and_gate : directed scoreboard bench for and_gate (CNT_W=8 and CNT_W=2)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_and_gate;

   logic       clk;
   logic       rst_n;
   logic       clk_run = 1'b0;
   logic       a, b, clr;
   logic       a2, b2, clr2;
   logic       out, out_q, rise_sat;
   logic [7:0] rise_cnt;
   logic       out2, out_q2, rise_sat2;
   logic [1:0] rise_cnt2;
`ifdef AND_GATE_HIGH_CNT_EN
   logic [7:0] high_cnt;
   logic [1:0] high_cnt2;
`endif

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;

   sb_t sb[$];
   int  n_pass  = 0;
   int  n_total = 0;

   and_gate #(.CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
      .out(out), .out_q(out_q), .rise_cnt(rise_cnt), .rise_sat(rise_sat)
`ifdef AND_GATE_HIGH_CNT_EN
     ,.high_cnt(high_cnt)
`endif
   );

   and_gate #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .clr(clr2),
      .out(out2), .out_q(out_q2), .rise_cnt(rise_cnt2), .rise_sat(rise_sat2)
`ifdef AND_GATE_HIGH_CNT_EN
     ,.high_cnt(high_cnt2)
`endif
   );

   always #5 if (clk_run) clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push(input string tag, input logic [31:0] exp);
      sb_t e;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      sb_t e;
      n_total++;
      if (sb.size() == 0) begin
         $error("FAIL sb_empty: observed %0d expected none", obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] ab;
      int         exp_r;

      clr = 1'b0; a2 = 1'b0; b2 = 1'b0; clr2 = 1'b0;

      // Combinational path with clk and rst_n left undriven.
      for (int i = 0; i < 4; i++) begin
         ab = i[1:0];
         a  = ab[1];
         b  = ab[0];
         #10;
         push($sformatf("out_ab%0d%0d", ab[1], ab[0]), {31'b0, ab[1] & ab[0]});
         chk({31'b0, out});
      end
      a = 1'b0; b = 1'bx;
      #10;
      push("out_a0_bx", 32'd0);
      chk({31'b0, out});

      // Reset held with clock running.
      rst_n = 1'b0;
      #1;
      push("rst_out_q", 0); chk({31'b0, out_q});
      push("rst_rise_cnt", 0); chk({24'b0, rise_cnt});
      push("rst_rise_sat", 0); chk({31'b0, rise_sat});
      clk = 1'b0;
      clk_run = 1'b1;
      a = 1'b1; b = 1'b1;
      tick(); tick();
      push("inrst_out", 1); chk({31'b0, out});
      push("inrst_out_q", 0); chk({31'b0, out_q});
      push("inrst_rise_cnt", 0); chk({24'b0, rise_cnt});
      rst_n = 1'b1;
      tick();
      push("rel_out_q", 1); chk({31'b0, out_q});
      push("rel_rise_cnt", 1); chk({24'b0, rise_cnt});
      push("rel_rise_sat", 0); chk({31'b0, rise_sat});

      // Second rise, then asynchronous reset between edges.
      a = 1'b0; tick();
      push("fall_out_q", 0); chk({31'b0, out_q});
      push("fall_rise_cnt", 1); chk({24'b0, rise_cnt});
      a = 1'b1; tick();
      push("rise2_cnt", 2); chk({24'b0, rise_cnt});
      #2 rst_n = 1'b0;
      #1;
      push("arst_out_q", 0); chk({31'b0, out_q});
      push("arst_rise_cnt", 0); chk({24'b0, rise_cnt});
      push("arst_rise_sat", 0); chk({31'b0, rise_sat});
      push("arst_out", 1); chk({31'b0, out});
`ifdef AND_GATE_HIGH_CNT_EN
      push("arst_high_cnt", 0); chk({24'b0, high_cnt});
`endif
      rst_n = 1'b1;
      tick();
      push("rerel_out_q", 1); chk({31'b0, out_q});
      push("rerel_rise_cnt", 1); chk({24'b0, rise_cnt});

      // clr on the same edge as a rise: no count, out_q still updates.
      a = 1'b0; tick();
      a = 1'b1; clr = 1'b1; tick();
      clr = 1'b0;
      push("clr_rise_cnt", 0); chk({24'b0, rise_cnt});
      push("clr_out_q", 1); chk({31'b0, out_q});
      tick();
      push("clr_hold_cnt", 0); chk({24'b0, rise_cnt});

`ifdef AND_GATE_HIGH_CNT_EN
      clr = 1'b1; tick(); clr = 1'b0;
      push("high_clr", 0); chk({24'b0, high_cnt});
      repeat (4) tick();
      push("high_cnt4", 4); chk({24'b0, high_cnt});
`endif

      // CNT_W=2 instance: five rises saturate at 3.
      for (int i = 1; i <= 5; i++) begin
         a2 = 1'b1; b2 = 1'b1; tick();
         exp_r = (i < 3) ? i : 3;
         push($sformatf("w2_cnt_r%0d", i), exp_r); chk({30'b0, rise_cnt2});
         push($sformatf("w2_sat_r%0d", i), (i >= 3) ? 1 : 0); chk({31'b0, rise_sat2});
         a2 = 1'b0; tick();
      end
      push("w2_out_q_low", 0); chk({31'b0, out_q2});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
